// File: rtl/mc_controller.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and decodes every datapath select and write enable from the state.
module mc_controller #(
    parameter logic MEM_WAIT_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_en_o,
    output logic       iord_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_control_o,
    output logic [1:0] pc_src_o,
    output logic       instr_done_o,
    output logic       illegal_op_o
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Returns 1 for the five supported R-type functions.
    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default:                                              funct_ok = 1'b0;
        endcase
    endfunction

    // ALU operation for an R-type function field.
    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_alu = 3'b000;
        endcase
    endfunction

    state_t state_q;
    state_t state_d;
    logic   ready_s;

    assign ready_s = MEM_WAIT_EN ? mem_ready_i : 1'b1;

    // Next-state selection; unencoded states fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = ready_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_ok(funct_i) ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = ready_s ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = ready_s ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode: state-based, with pc_en/ir_write qualified by ready/zero.
    always_comb begin
        pc_en_o       = 1'b0;
        iord_o        = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        reg_write_o   = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        alu_control_o = 3'b000;
        pc_src_o      = 2'b00;
        instr_done_o  = 1'b0;
        illegal_op_o  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b_o   = 2'b01;
                alu_control_o = 3'b010;
                pc_en_o       = ready_s;
                ir_write_o    = ready_s;
            end
            S_DECODE: begin
                alu_src_b_o   = 2'b11;
                alu_control_o = 3'b010;
                case (op_i)
                    OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_op_o = 1'b0;
                    OP_RTYPE: illegal_op_o = ~funct_ok(funct_i);
                    default:  illegal_op_o = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a_o   = 1'b1;
                alu_src_b_o   = 2'b10;
                alu_control_o = 3'b010;
            end
            S_MEMRD: iord_o = 1'b1;
            S_MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEMWR: begin
                iord_o       = 1'b1;
                mem_write_o  = 1'b1;
                instr_done_o = ready_s;
            end
            S_EXECUTE: begin
                alu_src_a_o   = 1'b1;
                alu_control_o = funct_alu(funct_i);
            end
            S_ALUWB: begin
                reg_dst_o    = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o   = 1'b1;
                alu_control_o = 3'b110;
                pc_src_o      = 2'b01;
                pc_en_o       = zero_i;
                instr_done_o  = 1'b1;
            end
            S_ADDIWB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_JUMP: begin
                pc_src_o     = 2'b10;
                pc_en_o      = 1'b1;
                instr_done_o = 1'b1;
            end
            default: pc_en_o = 1'b0;
        endcase
        // No enable or pulse may fire while reset is being applied.
        if (reset_i) begin
            pc_en_o      = 1'b0;
            ir_write_o   = 1'b0;
            mem_write_o  = 1'b0;
            reg_write_o  = 1'b0;
            instr_done_o = 1'b0;
            illegal_op_o = 1'b0;
        end else begin
            instr_done_o = instr_done_o;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed vector table, hand-written stall/reset
// sequences, and random instruction streams against a phase-list reference model.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       instr_done, illegal_op;

    mc_controller #(.MEM_WAIT_EN(1'b1)) dut (
        .clk_i(clk), .reset_i(reset), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(mem_ready), .pc_en_o(pc_en), .iord_o(iord), .mem_write_o(mem_write),
        .ir_write_o(ir_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
        .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .alu_control_o(alu_control), .pc_src_o(pc_src), .instr_done_o(instr_done),
        .illegal_op_o(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       instr_done, illegal_op;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op, funct;
        logic       zero, rdy;
        outs_t      exp;
        logic       full;
    } vec_t;

    typedef enum {P_F, P_D, P_MA, P_MR, P_MB, P_MW, P_EX, P_AW, P_BR, P_AE, P_AB, P_J} ph_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    // flags: {pc_en iord mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a}, asb, alu, pc_src, {done ill}
    localparam outs_t X_F1    = {8'b1001_0000, 2'b01, 3'b010, 2'b00, 2'b00};
    localparam outs_t X_F0    = {8'b0000_0000, 2'b01, 3'b010, 2'b00, 2'b00};
    localparam outs_t X_DEC   = {8'b0000_0000, 2'b11, 3'b010, 2'b00, 2'b00};
    localparam outs_t X_ILL   = {8'b0000_0000, 2'b11, 3'b010, 2'b00, 2'b01};
    localparam outs_t X_MA    = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 2'b00};
    localparam outs_t X_MR    = {8'b0100_0000, 2'b00, 3'b000, 2'b00, 2'b00};
    localparam outs_t X_MB    = {8'b0000_0110, 2'b00, 3'b000, 2'b00, 2'b10};
    localparam outs_t X_MW0   = {8'b0110_0000, 2'b00, 3'b000, 2'b00, 2'b00};
    localparam outs_t X_MW1   = {8'b0110_0000, 2'b00, 3'b000, 2'b00, 2'b10};
    localparam outs_t X_EXSLT = {8'b0000_0001, 2'b00, 3'b111, 2'b00, 2'b00};
    localparam outs_t X_EXSUB = {8'b0000_0001, 2'b00, 3'b110, 2'b00, 2'b00};
    localparam outs_t X_AW    = {8'b0000_1010, 2'b00, 3'b000, 2'b00, 2'b10};
    localparam outs_t X_BR1   = {8'b1000_0001, 2'b00, 3'b110, 2'b01, 2'b10};
    localparam outs_t X_BR0   = {8'b0000_0001, 2'b00, 3'b110, 2'b01, 2'b10};
    localparam outs_t X_AE    = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 2'b00};
    localparam outs_t X_AB    = {8'b0000_0010, 2'b00, 3'b000, 2'b00, 2'b10};
    localparam outs_t X_J     = {8'b1000_0000, 2'b00, 3'b000, 2'b10, 2'b10};
    localparam outs_t X_RST   = {8'b0000_0000, 2'b00, 3'b000, 2'b00, 2'b00};
    localparam outs_t EN_MASK = {8'b1011_0010, 2'b00, 3'b000, 2'b00, 2'b11};

    int total = 0;
    int bad = 0;
    int mw_seen = 0;
    int done_seen = 0;

    task automatic cyc(input logic r, input logic [5:0] o_, input logic [5:0] f_,
                       input logic z, input logic rd, input outs_t exp, input logic full,
                       input string nm);
        outs_t act;
        outs_t m;
        reset = r; op = o_; funct = f_; zero = z; mem_ready = rd;
        #1;
        act = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_control, pc_src, instr_done, illegal_op};
        m = full ? outs_t'({17{1'b1}}) : EN_MASK;
        total++;
        if ((act & m) !== (exp & m)) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act & m, exp & m);
        end
        mw_seen += int'(mem_write);
        done_seen += int'(instr_done);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t v(input logic r, input logic [5:0] o_, input logic [5:0] f_,
                               input logic z, input logic rd, input outs_t e, input logic full);
        vec_t t;
        t.rst = r; t.op = o_; t.funct = f_; t.zero = z; t.rdy = rd; t.exp = e; t.full = full;
        return t;
    endfunction

    function automatic logic legal(input logic [5:0] o_, input logic [5:0] f_);
        logic [5:0] ok_ops [5] = '{LW, SW, BEQ, ADDI, JMP};
        logic [5:0] ok_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        if (o_ == RT) begin
            foreach (ok_fn[i]) if (ok_fn[i] == f_) return 1'b1;
            return 1'b0;
        end
        foreach (ok_ops[i]) if (ok_ops[i] == o_) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f_);
        logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] al [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        foreach (fn[i]) if (fn[i] == f_) return al[i];
        return 3'b000;
    endfunction

    function automatic outs_t ref_out(input ph_t ph, input logic rdy, input logic z,
                                      input logic [5:0] o_, input logic [5:0] f_);
        outs_t e = '0;
        case (ph)
            P_F:  begin e.pc_en = rdy; e.ir_write = rdy; e.alu_src_b = 2'b01; e.alu_control = 3'b010; end
            P_D:  begin e.alu_src_b = 2'b11; e.alu_control = 3'b010; e.illegal_op = !legal(o_, f_); end
            P_MA, P_AE: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
            P_MR: e.iord = 1'b1;
            P_MB: begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1; end
            P_MW: begin e.iord = 1'b1; e.mem_write = 1'b1; e.instr_done = rdy; end
            P_EX: begin e.alu_src_a = 1'b1; e.alu_control = alu_of(f_); end
            P_AW: begin e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1; end
            P_BR: begin e.alu_src_a = 1'b1; e.alu_control = 3'b110; e.pc_src = 2'b01;
                        e.pc_en = z; e.instr_done = 1'b1; end
            P_AB: begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
            P_J:  begin e.pc_src = 2'b10; e.pc_en = 1'b1; e.instr_done = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    initial begin
        vec_t tbl[$];
        ph_t plan[$];
        logic [5:0] rops [7];
        logic [5:0] rfns [6];
        logic [5:0] o_r, f_r;
        logic rdy_r, z_r;
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

        tbl.push_back(v(1'b1, LW, 6'd0, 1'b0, 1'b1, X_RST, 1'b0));
        tbl.push_back(v(1'b1, LW, 6'd0, 1'b0, 1'b1, X_RST, 1'b0));
        tbl.push_back(v(1'b0, LW, 6'd0, 1'b0, 1'b1, X_F1, 1'b1));
        tbl.push_back(v(1'b0, LW, 6'd0, 1'b0, 1'b1, X_DEC, 1'b1));
        tbl.push_back(v(1'b0, LW, 6'd0, 1'b0, 1'b1, X_MA, 1'b1));
        tbl.push_back(v(1'b0, LW, 6'd0, 1'b0, 1'b1, X_MR, 1'b1));
        tbl.push_back(v(1'b0, LW, 6'd0, 1'b0, 1'b1, X_MB, 1'b1));
        tbl.push_back(v(1'b0, BEQ, 6'd0, 1'b1, 1'b1, X_F1, 1'b1));
        tbl.push_back(v(1'b0, BEQ, 6'd0, 1'b1, 1'b1, X_DEC, 1'b1));
        tbl.push_back(v(1'b0, BEQ, 6'd0, 1'b1, 1'b1, X_BR1, 1'b1));
        tbl.push_back(v(1'b0, BEQ, 6'd0, 1'b0, 1'b1, X_F1, 1'b1));
        tbl.push_back(v(1'b0, BEQ, 6'd0, 1'b0, 1'b1, X_DEC, 1'b1));
        tbl.push_back(v(1'b0, BEQ, 6'd0, 1'b0, 1'b1, X_BR0, 1'b1));
        tbl.push_back(v(1'b0, JMP, 6'd0, 1'b0, 1'b1, X_F1, 1'b1));
        tbl.push_back(v(1'b0, JMP, 6'd0, 1'b0, 1'b1, X_DEC, 1'b1));
        tbl.push_back(v(1'b0, JMP, 6'd0, 1'b0, 1'b1, X_J, 1'b1));
        tbl.push_back(v(1'b0, BAD, 6'd0, 1'b0, 1'b1, X_F1, 1'b1));
        tbl.push_back(v(1'b0, BAD, 6'd0, 1'b0, 1'b1, X_ILL, 1'b1));
        tbl.push_back(v(1'b0, RT, 6'b101010, 1'b0, 1'b1, X_F1, 1'b1));
        tbl.push_back(v(1'b0, RT, 6'b101010, 1'b0, 1'b1, X_DEC, 1'b1));
        tbl.push_back(v(1'b0, RT, 6'b101010, 1'b0, 1'b1, X_EXSLT, 1'b1));
        tbl.push_back(v(1'b0, RT, 6'b101010, 1'b0, 1'b1, X_AW, 1'b1));
        tbl.push_back(v(1'b0, RT, 6'b100010, 1'b0, 1'b1, X_F1, 1'b1));
        tbl.push_back(v(1'b0, RT, 6'b100010, 1'b0, 1'b1, X_DEC, 1'b1));
        tbl.push_back(v(1'b0, RT, 6'b100010, 1'b0, 1'b1, X_EXSUB, 1'b1));
        tbl.push_back(v(1'b0, RT, 6'b100010, 1'b0, 1'b1, X_AW, 1'b1));
        tbl.push_back(v(1'b0, ADDI, 6'd0, 1'b0, 1'b1, X_F1, 1'b1));
        tbl.push_back(v(1'b0, ADDI, 6'd0, 1'b0, 1'b1, X_DEC, 1'b1));
        tbl.push_back(v(1'b0, ADDI, 6'd0, 1'b0, 1'b1, X_AE, 1'b1));
        tbl.push_back(v(1'b0, ADDI, 6'd0, 1'b0, 1'b1, X_AB, 1'b1));
        tbl.push_back(v(1'b0, RT, 6'b000001, 1'b0, 1'b1, X_F1, 1'b1));
        tbl.push_back(v(1'b0, RT, 6'b000001, 1'b0, 1'b1, X_ILL, 1'b1));
        tbl.push_back(v(1'b0, JMP, 6'd0, 1'b0, 1'b0, X_F0, 1'b1));
        tbl.push_back(v(1'b0, JMP, 6'd0, 1'b0, 1'b1, X_F1, 1'b1));
        tbl.push_back(v(1'b0, JMP, 6'd0, 1'b0, 1'b1, X_DEC, 1'b1));
        tbl.push_back(v(1'b0, JMP, 6'd0, 1'b0, 1'b1, X_J, 1'b1));
        foreach (tbl[i])
            cyc(tbl[i].rst, tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].rdy,
                tbl[i].exp, tbl[i].full, $sformatf("vec%0d", i));

        // sw with three stalled write cycles
        cyc(1'b0, SW, 6'd0, 1'b0, 1'b1, X_F1, 1'b1, "sw_fetch");
        cyc(1'b0, SW, 6'd0, 1'b0, 1'b1, X_DEC, 1'b1, "sw_decode");
        cyc(1'b0, SW, 6'd0, 1'b0, 1'b1, X_MA, 1'b1, "sw_memadr");
        mw_seen = 0;
        done_seen = 0;
        for (int i = 0; i < 3; i++)
            cyc(1'b0, SW, 6'd0, 1'b0, 1'b0, X_MW0, 1'b1, "sw_stall");
        cyc(1'b0, SW, 6'd0, 1'b0, 1'b1, X_MW1, 1'b1, "sw_done");
        total++;
        if (mw_seen != 4 || done_seen != 1) begin
            bad++;
            $display("FAIL sw_counts: got mem_write=%0d done=%0d want 4 1", mw_seen, done_seen);
        end
        cyc(1'b0, SW, 6'd0, 1'b0, 1'b1, X_F1, 1'b1, "sw_refetch");

        // reset during a MEMRD stall
        cyc(1'b0, LW, 6'd0, 1'b0, 1'b1, X_DEC, 1'b1, "rs_decode");
        cyc(1'b0, LW, 6'd0, 1'b0, 1'b1, X_MA, 1'b1, "rs_memadr");
        cyc(1'b0, LW, 6'd0, 1'b0, 1'b0, X_MR, 1'b1, "rs_stall");
        cyc(1'b1, LW, 6'd0, 1'b0, 1'b0, X_RST, 1'b0, "rs_reset");
        cyc(1'b0, LW, 6'd0, 1'b0, 1'b1, X_F1, 1'b1, "rs_fetch");
        cyc(1'b0, LW, 6'd0, 1'b0, 1'b1, X_DEC, 1'b1, "rs_decode2");
        cyc(1'b0, LW, 6'd0, 1'b0, 1'b1, X_MA, 1'b1, "rs_memadr2");
        cyc(1'b0, LW, 6'd0, 1'b0, 1'b1, X_MR, 1'b1, "rs_memrd2");
        cyc(1'b0, LW, 6'd0, 1'b0, 1'b1, X_MB, 1'b1, "rs_memwb2");

        // random instruction stream against the phase-list model
        rops = '{LW, SW, RT, BEQ, ADDI, JMP, 6'd0};
        rfns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'd0};
        for (int n = 0; n < 300; n++) begin
            rops[6] = 6'($urandom_range(0, 63));
            rfns[5] = 6'($urandom_range(0, 63));
            o_r = rops[$urandom_range(0, 6)];
            f_r = rfns[$urandom_range(0, 5)];
            plan = '{P_F, P_D};
            if (legal(o_r, f_r)) begin
                case (o_r)
                    LW:      plan = '{P_F, P_D, P_MA, P_MR, P_MB};
                    SW:      plan = '{P_F, P_D, P_MA, P_MW};
                    RT:      plan = '{P_F, P_D, P_EX, P_AW};
                    BEQ:     plan = '{P_F, P_D, P_BR};
                    ADDI:    plan = '{P_F, P_D, P_AE, P_AB};
                    default: plan = '{P_F, P_D, P_J};
                endcase
            end
            while (plan.size() > 0) begin
                rdy_r = ($urandom_range(0, 3) != 0);
                z_r = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 79) == 0) begin
                    cyc(1'b1, o_r, f_r, z_r, rdy_r, X_RST, 1'b0, "rand_reset");
                    plan.delete();
                end else begin
                    cyc(1'b0, o_r, f_r, z_r, rdy_r, ref_out(plan[0], rdy_r, z_r, o_r, f_r), 1'b1,
                        $sformatf("rand_n%0d_ph%0d", n, plan[0]));
                    if (rdy_r || !(plan[0] == P_F || plan[0] == P_MR || plan[0] == P_MW))
                        void'(plan.pop_front());
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
